// File: rtl/stack_engine_pkg.sv
// Shared definitions for the MiniRISC stack sequencer.
// Holds the PUSH/POP operation codes seen by both the controller FSM and
// stack_engine, plus the engine's state encoding.
package stack_engine_pkg;

    // Operation code carried on the controller's push_or_pop line.
    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } stack_op_e;

    // Sequencer states.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } stack_state_e;

endpackage

// File: rtl/stack_engine_if.sv
// Data-memory bus shared between the stack engine and other bus masters.
// Signals:
//   bus_req   - master requests a beat
//   bus_grant - beat completes in the cycle this is high
//   mem_addr  - beat address
//   mem_wr    - write strobe
//   mem_rd    - read strobe
//   mem_dout  - write data (master to memory)
//   mem_din   - read data (memory to master), valid in the grant cycle
interface stack_engine_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              bus_req;
    logic              bus_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_din;

    modport master (
        output bus_req,
        output mem_addr,
        output mem_wr,
        output mem_rd,
        output mem_dout,
        input  bus_grant,
        input  mem_din
    );

    modport slave (
        input  bus_req,
        input  mem_addr,
        input  mem_wr,
        input  mem_rd,
        input  mem_dout,
        output bus_grant,
        output mem_din
    );
endinterface

// File: rtl/stack_engine.sv
// Multi-word stack sequencer for the MiniRISC CPU.
// Pushes or pops a WORDS-word frame over the shared data-memory bus, owns
// the stack pointer and refuses operations that would overflow/underflow.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   start, op      - operation request (level, sampled in IDLE) and PUSH/POP
//   frame_in       - push data, word k at [k*DATA_W +: DATA_W]
//   frame_out      - registered pop result
//   done           - operation finished (combinational), to stack_op_end
//   busy           - sequencer not idle
//   err_ovf/unf    - sticky refusal flags, cleared by err_clr
//   sp             - stack pointer (next free slot, grows downward)
//   sp_wr, sp_din  - debug SP load, honoured only in IDLE with start low
//   bus            - data-memory bus, master side
module stack_engine
    import stack_engine_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       WORDS       = 2,
    parameter logic [ADDR_W-1:0] STACK_BASE  = '1,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 'hF0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    op,
    input  logic [WORDS*DATA_W-1:0] frame_in,
    output logic [WORDS*DATA_W-1:0] frame_out,
    output logic                    done,
    output logic                    busy,
    output logic                    err_ovf,
    output logic                    err_unf,
    input  logic                    err_clr,
    output logic [ADDR_W-1:0]       sp,
    input  logic                    sp_wr,
    input  logic [ADDR_W-1:0]       sp_din,
    stack_engine_if.master          bus
);

    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Bounds arithmetic is done one bit wider than the address.
    localparam logic [ADDR_W:0] BASE_X  = {1'b0, STACK_BASE};
    localparam logic [ADDR_W:0] LIMIT_X = {1'b0, STACK_LIMIT};
    localparam logic [ADDR_W:0] WORDS_X = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W:0] ONE_X   = (ADDR_W+1)'(1);
    localparam logic [KW-1:0]   K_LAST  = KW'(WORDS-1);

    stack_state_e              state_q, state_d;
    stack_op_e                 op_q, op_d;
    logic [KW-1:0]             k_q, k_d;
    logic [ADDR_W-1:0]         sp_q, sp_d;
    logic [WORDS*DATA_W-1:0]   frame_q, frame_d;
    logic [WORDS*DATA_W-1:0]   fout_q, fout_d;
    logic                      ovf_q, ovf_d;
    logic                      unf_q, unf_d;

    logic                      push_ok;
    logic                      pop_ok;
    logic                      legal;
    int unsigned               kidx;

    assign push_ok = (({1'b0, sp_q} - LIMIT_X + ONE_X) >= WORDS_X);
    assign pop_ok  = ((BASE_X - {1'b0, sp_q}) >= WORDS_X);
    assign kidx    = 32'(k_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_PUSH;
            k_q     <= '0;
            sp_q    <= STACK_BASE;
            frame_q <= '0;
            fout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            k_q     <= k_d;
            sp_q    <= sp_d;
            frame_q <= frame_d;
            fout_q  <= fout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        k_d     = k_q;
        sp_d    = sp_q;
        frame_d = frame_q;
        fout_d  = fout_q;
        // A new error in the same cycle as err_clr overrides the clear below.
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        legal   = 1'b0;

        done         = 1'b0;
        bus.bus_req  = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_dout = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    legal = (op == OP_POP) ? pop_ok : push_ok;
                    if (!legal) begin
                        // Refused request completes immediately, no bus traffic.
                        done = 1'b1;
                        if (op == OP_POP) unf_d = 1'b1;
                        else              ovf_d = 1'b1;
                    end else begin
                        state_d = S_XFER;
                        k_d     = '0;
                        op_d    = stack_op_e'(op);
                        frame_d = frame_in;
                    end
                end else if (sp_wr) begin
                    sp_d = sp_din;
                end
            end

            S_XFER: begin
                bus.bus_req = 1'b1;
                if (op_q == OP_POP) begin
                    // Pop pre-increments: the beat reads the slot above SP.
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = sp_q + ADDR_W'(1);
                end else begin
                    bus.mem_wr   = 1'b1;
                    bus.mem_addr = sp_q;
                    bus.mem_dout = frame_q[kidx*DATA_W +: DATA_W];
                end

                if (bus.bus_grant) begin
                    if (op_q == OP_POP) begin
                        sp_d = sp_q + ADDR_W'(1);
                        // Pops fill from the top word down so frames round-trip.
                        fout_d[(WORDS-1-kidx)*DATA_W +: DATA_W] = bus.mem_din;
                    end else begin
                        sp_d = sp_q - ADDR_W'(1);
                    end

                    if (k_q == K_LAST) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign frame_out = fout_q;
    assign busy      = (state_q != S_IDLE);
    assign err_ovf   = ovf_q;
    assign err_unf   = unf_q;
    assign sp        = sp_q;

endmodule
